// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter for the single register-file write port, plus a
// sequencer that zeroes every register through that same port.
module reg_write_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 3
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [NUM_REQ-1:0]        REQ,
  input  logic [NUM_REQ*DATA_W-1:0] REQ_DATA,
  input  logic [NUM_REQ*ADDR_W-1:0] REQ_ADDR,
  output logic [NUM_REQ-1:0]        GNT,
  input  logic                      CLEAR_START,
  output logic                      CLEAR_BUSY,
  output logic [DATA_W-1:0]         RF_IN,
  output logic [ADDR_W-1:0]         RF_INADDRESS,
  output logic                      RF_WRITE
);

  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t             state;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   sel;
  logic [PTR_W:0]     cand;
  logic               found;
  logic [ADDR_W-1:0]  clr_cnt;

  // Scan requesters starting at ptr, wrapping modulo NUM_REQ; first hit wins.
  // NOTE: every signal gets a default before the loop so no latch is inferred.
  always_comb begin
    found = 1'b0;
    sel   = ptr;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr} + (PTR_W+1)'(k);
      if (cand >= (PTR_W+1)'(NUM_REQ)) cand = cand - (PTR_W+1)'(NUM_REQ);
      if (!found && REQ[cand[PTR_W-1:0]]) begin
        found = 1'b1;
        sel   = cand[PTR_W-1:0];
      end
    end
  end

  // NOTE: all state and outputs update with non-blocking assignments so every
  // right-hand side sees the pre-edge values.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state        <= IDLE;
      ptr          <= '0;
      clr_cnt      <= '0;
      GNT          <= '0;
      RF_WRITE     <= 1'b0;
      RF_IN        <= '0;
      RF_INADDRESS <= '0;
    end else begin
      GNT      <= '0;
      RF_WRITE <= 1'b0;
      case (state)
        IDLE: begin
          if (CLEAR_START) begin
            state   <= CLEAR;
            clr_cnt <= '0;
          end else if (found) begin
            GNT          <= NUM_REQ'(1) << sel;
            RF_WRITE     <= 1'b1;
            RF_IN        <= REQ_DATA[int'(sel)*DATA_W +: DATA_W];
            RF_INADDRESS <= REQ_ADDR[int'(sel)*ADDR_W +: ADDR_W];
            ptr          <= (int'(sel) == NUM_REQ-1) ? '0 : sel + PTR_W'(1);
          end
        end
        CLEAR: begin
          RF_WRITE     <= 1'b1;
          RF_IN        <= '0;
          RF_INADDRESS <= clr_cnt;
          clr_cnt      <= clr_cnt + ADDR_W'(1);
          // Last address leaves the counter wrapped back to zero.
          if (clr_cnt == '1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign CLEAR_BUSY = (state == CLEAR);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: vector table, hand-written
// clear/reset/collision sequences, and randomized traffic against a queue model.
module tb_reg_write_arbiter;

  localparam int NR = 3;
  localparam int DW = 8;
  localparam int AW = 3;

  logic            CLK = 1'b0;
  logic            RESET = 1'b0;
  logic [NR-1:0]   REQ = '0;
  logic [NR*DW-1:0] REQ_DATA = '0;
  logic [NR*AW-1:0] REQ_ADDR = '0;
  logic [NR-1:0]   GNT;
  logic            CLEAR_START = 1'b0;
  logic            CLEAR_BUSY;
  logic [DW-1:0]   RF_IN;
  logic [AW-1:0]   RF_INADDRESS;
  logic            RF_WRITE;

  int tests = 0;
  int fails = 0;

  reg_write_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .ADDR_W(AW)) dut (
    .CLK(CLK), .RESET(RESET), .REQ(REQ), .REQ_DATA(REQ_DATA), .REQ_ADDR(REQ_ADDR),
    .GNT(GNT), .CLEAR_START(CLEAR_START), .CLEAR_BUSY(CLEAR_BUSY),
    .RF_IN(RF_IN), .RF_INADDRESS(RF_INADDRESS), .RF_WRITE(RF_WRITE)
  );

  always #5 CLK = ~CLK;

  // Register file fed by the arbiter outputs.
  logic [DW-1:0] rf [8];
  always @(posedge CLK) if (RF_WRITE === 1'b1) rf[RF_INADDRESS] <= RF_IN;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [2:0] g, input logic w,
                            input logic [7:0] d, input logic [2:0] a, input logic b);
    check({tag, " gnt"},  32'(GNT), 32'(g));
    check({tag, " wr"},   32'(RF_WRITE), 32'(w));
    check({tag, " in"},   32'(RF_IN), 32'(d));
    check({tag, " addr"}, 32'(RF_INADDRESS), 32'(a));
    check({tag, " busy"}, 32'(CLEAR_BUSY), 32'(b));
  endtask

  typedef struct {
    logic [2:0]  req;
    logic [23:0] data;
    logic [8:0]  addr;
    logic        clr;
    logic [2:0]  gnt;
    logic        wr;
    logic [7:0]  din;
    logic [2:0]  dad;
    logic        busy;
  } vec_t;

  vec_t tbl [11];

  // Reference model: pending clear addresses as a queue, arbitration as
  // "smallest wrap distance from the pointer".
  int            m_ptr;
  int            clr_q [$];
  logic [2:0]    e_gnt;
  logic          e_wr;
  logic [7:0]    e_in;
  logic [2:0]    e_addr;

  task automatic model_edge();
    int best, best_d, d;
    e_gnt = '0;
    e_wr  = 1'b0;
    if (clr_q.size() != 0) begin
      e_wr   = 1'b1;
      e_in   = 8'h00;
      e_addr = 3'(clr_q.pop_front());
    end else if (CLEAR_START) begin
      for (int a = 0; a < 8; a++) clr_q.push_back(a);
    end else begin
      best = -1;
      best_d = NR;
      for (int i = 0; i < NR; i++) begin
        d = (i - m_ptr + NR) % NR;
        if (REQ[i] && d < best_d) begin
          best = i;
          best_d = d;
        end
      end
      if (best >= 0) begin
        e_gnt[best] = 1'b1;
        e_wr   = 1'b1;
        e_in   = REQ_DATA[best*DW +: DW];
        e_addr = REQ_ADDR[best*AW +: AW];
        m_ptr  = (best + 1) % NR;
      end
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{3'b010, 24'h005A00, 9'b000_011_000, 1'b0, 3'b010, 1'b1, 8'h5A, 3'd3, 1'b0};
    tbl[1]  = '{3'b000, 24'h332211, 9'b110_101_100, 1'b0, 3'b000, 1'b0, 8'h5A, 3'd3, 1'b0};
    tbl[2]  = '{3'b111, 24'h332211, 9'b110_101_100, 1'b0, 3'b100, 1'b1, 8'h33, 3'd6, 1'b0};
    tbl[3]  = '{3'b111, 24'h332211, 9'b110_101_100, 1'b0, 3'b001, 1'b1, 8'h11, 3'd4, 1'b0};
    tbl[4]  = '{3'b111, 24'h332211, 9'b110_101_100, 1'b0, 3'b010, 1'b1, 8'h22, 3'd5, 1'b0};
    tbl[5]  = '{3'b111, 24'h332211, 9'b110_101_100, 1'b0, 3'b100, 1'b1, 8'h33, 3'd6, 1'b0};
    tbl[6]  = '{3'b101, 24'h332211, 9'b110_101_100, 1'b0, 3'b001, 1'b1, 8'h11, 3'd4, 1'b0};
    tbl[7]  = '{3'b101, 24'h332211, 9'b110_101_100, 1'b0, 3'b100, 1'b1, 8'h33, 3'd6, 1'b0};
    tbl[8]  = '{3'b000, 24'h332211, 9'b110_101_100, 1'b0, 3'b000, 1'b0, 8'h33, 3'd6, 1'b0};
    tbl[9]  = '{3'b100, 24'h332211, 9'b110_101_100, 1'b0, 3'b100, 1'b1, 8'h33, 3'd6, 1'b0};
    tbl[10] = '{3'b100, 24'h332211, 9'b110_101_100, 1'b0, 3'b100, 1'b1, 8'h33, 3'd6, 1'b0};

    // Power-on reset
    #12;
    check_outs("reset", 3'b000, 1'b0, 8'h00, 3'd0, 1'b0);
    @(negedge CLK);
    RESET = 1'b1;

    // Table: single write, round robin from various pointers, lone requester
    foreach (tbl[n]) begin
      REQ = tbl[n].req;
      REQ_DATA = tbl[n].data;
      REQ_ADDR = tbl[n].addr;
      CLEAR_START = tbl[n].clr;
      step();
      check_outs($sformatf("vec%0d", n), tbl[n].gnt, tbl[n].wr, tbl[n].din, tbl[n].dad, tbl[n].busy);
    end
    REQ = '0;

    // Clear sequence
    CLEAR_START = 1'b1;
    step();
    CLEAR_START = 1'b0;
    check_outs("clr start", 3'b000, 1'b0, 8'h33, 3'd6, 1'b1);
    for (int k = 0; k < 8; k++) begin
      step();
      check_outs($sformatf("clr%0d", k), 3'b000, 1'b1, 8'h00, 3'(k), (k < 7) ? 1'b1 : 1'b0);
    end
    step();
    check("clr done wr", 32'(RF_WRITE), 32'd0);
    for (int a = 0; a < 8; a++) check($sformatf("rf%0d zero", a), 32'(rf[a]), 32'd0);

    // Clear and request at the same edge: clear wins, request granted afterwards
    REQ = 3'b001;
    REQ_DATA = 24'h000077;
    REQ_ADDR = 9'd2;
    CLEAR_START = 1'b1;
    step();
    CLEAR_START = 1'b0;
    check("coll start gnt", 32'(GNT), 32'd0);
    check("coll start busy", 32'(CLEAR_BUSY), 32'd1);
    for (int k = 0; k < 8; k++) begin
      step();
      check($sformatf("coll gnt%0d", k), 32'(GNT), 32'd0);
    end
    step();
    check_outs("coll grant", 3'b001, 1'b1, 8'h77, 3'd2, 1'b0);
    REQ = '0;

    // Reset mid-clear, pointer returns to 0
    CLEAR_START = 1'b1;
    step();
    CLEAR_START = 1'b0;
    for (int k = 0; k < 5; k++) step();
    check("midclr addr4", 32'(RF_INADDRESS), 32'd4);
    #3 RESET = 1'b0;
    #1 check_outs("midclr reset", 3'b000, 1'b0, 8'h00, 3'd0, 1'b0);
    @(negedge CLK);
    RESET = 1'b1;
    REQ = 3'b101;
    REQ_DATA = 24'h332211;
    REQ_ADDR = 9'b110_101_100;
    step();
    check_outs("post reset", 3'b001, 1'b1, 8'h11, 3'd4, 1'b0);

    // Reset asserted mid-cycle with all requests high, then round robin from 0
    REQ = 3'b111;
    #3 RESET = 1'b0;
    #1 check_outs("rst req111", 3'b000, 1'b0, 8'h00, 3'd0, 1'b0);
    step();
    check("rst hold gnt", 32'(GNT), 32'd0);
    @(negedge CLK);
    RESET = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      check($sformatf("rr%0d", k), 32'(GNT), 32'(3'b001 << (k % 3)));
    end
    REQ = '0;

    // Randomized traffic against the model
    #3 RESET = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    m_ptr = 0;
    clr_q.delete();
    e_in = '0;
    e_addr = '0;
    for (int c = 0; c < 400; c++) begin
      model_edge();
      step();
      check_outs($sformatf("rnd%0d", c), e_gnt, e_wr, e_in, e_addr, clr_q.size() != 0);
      for (int i = 0; i < NR; i++) begin
        if (e_gnt[i] || !REQ[i]) begin
          if ($urandom_range(1, 0) == 1) begin
            REQ[i] = 1'b1;
            REQ_DATA[i*DW +: DW] = 8'($urandom);
            REQ_ADDR[i*AW +: AW] = 3'($urandom);
          end else begin
            REQ[i] = 1'b0;
          end
        end else if ($urandom_range(9, 0) == 0) begin
          REQ[i] = 1'b0;
        end
      end
      CLEAR_START = ($urandom_range(39, 0) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
